banco_reg_param: RTL
====================

// Module: banco_reg_param
// PURPOSE
//  Parametrised register bank: DEPTH x WIDTH storage, one write port, two read ports.
//  Write select uses a parametrised one-hot address decoder (generalises the fixed 5->32 decoder).
//  Adds registered reads, an optional hardwired zero register and a sequential clear sweep.
//  Sits in the Banco_Reg datapath between instruction decode and the ALU operand muxes.
// PARAMETERS
//  WIDTH     32  data bits per register
//  DEPTH     32  number of registers, 2..256, need not be a power of 2
//  ZERO_REG  1   1: register 0 reads as 0 and ignores writes; 0: register 0 is ordinary
//  (localparam ADDR_W = $clog2(DEPTH))
// PORTS
//  clk       in   1       clock, all state updates on rising edge
//  rst_n     in   1       asynchronous, active-low reset
//  we        in   1       write enable
//  wa        in   ADDR_W  write address
//  wd        in   WIDTH   write data
//  re        in   1       read enable (both ports)
//  ra1       in   ADDR_W  read address, port 1
//  ra2       in   ADDR_W  read address, port 2
//  rd1       out  WIDTH   read data, port 1 (registered)
//  rd2       out  WIDTH   read data, port 2 (registered)
//  rd_valid  out  1       1-cycle pulse: rd1/rd2 updated
//  clr       in   1       start clear sweep (sampled in IDLE only)
//  busy      out  1       1 while clear sweep runs
// BEHAVIOUR
//  Reset (rst_n=0, async): all registers=0, rd1=rd2=0, rd_valid=0, busy=0, FSM=IDLE, sweep ptr=0.
//  Write: edge with we=1, busy=0, wa<DEPTH -> reg[wa]<=wd. Write to wa=0 is dropped when ZERO_REG=1.
//  Read: edge with re=1, busy=0 -> rd1<=reg[ra1], rd2<=reg[ra2], rd_valid<=1. Latency is 1 cycle.
//   When re=0, rd1/rd2 hold their values and rd_valid<=0.
//  Read data: ra>=DEPTH returns 0. Address 0 returns 0 when ZERO_REG=1.
//  Out-of-range write (wa>=DEPTH): no register changes and no error flag.
//  Same-edge read and write to the same address: see CONFIGURATION.
//  FSM IDLE -> CLEAR on clr=1 in IDLE. busy goes to 1 on the next cycle.
//  CLEAR: writes 0 to reg[ptr] and increments ptr, one register per cycle.
//   After ptr=DEPTH-1 -> IDLE with busy=0 and ptr=0. Total sweep = DEPTH cycles with busy=1.
//  During CLEAR: we, re and clr are ignored; rd_valid=0; rd1/rd2 hold.
//  clr together with we/re in IDLE: the same-edge write/read executes, then the sweep starts.
//  Reset mid-sweep: aborts immediately; all registers are 0 regardless of sweep progress.
// CONFIGURATION
//  Macro BANCO_REG_BYPASS_EN:
//   defined: same-edge we&re with ra==wa (write not dropped) -> rd gets wd (write-through).
//   undefined: read-before-write -> rd gets the old value; the new value is visible from the next read.
//  With ZERO_REG=1, address 0 never bypasses and always reads 0.
// STRUCTURE
//  Package banco_reg_pkg holds:
//   - typedef enum logic {IDLE, CLEAR} banco_state_t
//   - function clog2-safe ADDR_W helper
//   - reset constant RST_DATA = '0
//  Sub-module decodificador_param #(N=ADDR_W, M=DEPTH):
//   a -> one-hot y; y=0 for a>=M. Drives per-register write enables, gated by we & ~busy.
//  Read muxes and the FSM are in the top module.
// TESTING
//  1. Reset, then read ra1=5, ra2=31 -> rd1=0, rd2=0, rd_valid=1 one cycle after re.
//  2. Write 0xDEADBEEF to 7, next cycle read ra1=7 -> rd1=0xDEADBEEF. Write 0x1 to 0 (ZERO_REG=1), read 0 -> 0.
//  3. Same-edge write 0xA5A5A5A5 to 3 with read ra1=3 (old 0x11):
//      with BANCO_REG_BYPASS_EN -> 0xA5A5A5A5; without -> 0x11.
//  4. Fill regs 1..31 with their index, pulse clr -> busy=1 for exactly 32 cycles.
//     we/re during the sweep are ignored; after it, reading 1..31 gives 0.
//  5. DEPTH=20: write 0xFF to wa=25 -> no register changes. Read ra1=25 -> 0.
//  6. Deassert rst_n at sweep cycle 10 -> busy=0 immediately, all regs=0, FSM=IDLE.

Source files
------------

// File: rtl/banco_reg_pkg.sv
// Shared types and helpers for the parametrised register bank.
// Build option: BANCO_REG_BYPASS_EN selects write-through on same-edge read/write.
package banco_reg_pkg;

  typedef enum logic {
    IDLE,
    CLEAR
  } banco_state_t;

  localparam logic RST_DATA = 1'b0;

  // Address width that stays at least 1 bit even for tiny banks
  function automatic int addr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/banco_reg_param_decodificador_param.sv
// Parametrised one-hot decoder: a -> y, all-zero for a >= M.
// Drives the per-register write enables of the bank.
module decodificador_param #(
  parameter int N = 5,
  parameter int M = 32
) (
  input  logic [N-1:0] a,
  output logic [M-1:0] y
);

  for (genvar g = 0; g < M; g++) begin : g_dec
    assign y[g] = (a == N'(g));
  end

endmodule

// File: rtl/banco_reg_param.sv
// DEPTH x WIDTH register bank, 1 write / 2 registered read ports, clear sweep.
// Build option: BANCO_REG_BYPASS_EN (write-through on same-edge read/write).
module banco_reg_param
  import banco_reg_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  output logic              rd_valid,
  input  logic              clr,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [DEPTH-1:0] ZMASK =
    {{(DEPTH-1){1'b0}}, (ZERO_REG != 0)};

  banco_state_t      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  rd1_q, rd2_q;
  logic [WIDTH-1:0]  rd1_d, rd2_d;
  logic              rd_valid_q;

  logic [DEPTH-1:0]  dec_y;
  logic [DEPTH-1:0]  wen;
  logic              rd_fire;

  assign busy    = (state_q == CLEAR);
  assign rd_fire = re & ~busy;

  decodificador_param #(
    .N (ADDR_W),
    .M (DEPTH)
  ) u_dec (
    .a (wa),
    .y (dec_y)
  );

  assign wen = dec_y & {DEPTH{we & ~busy}} & ~ZMASK;

  // Sweep FSM next state: walk ptr 0..DEPTH-1 then return to IDLE
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (clr) state_d = CLEAR;
      end
      CLEAR: begin
        if (ptr_q == PTR_LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Sweep FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Storage: sweep clears one entry per cycle, else decoded write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= {WIDTH{RST_DATA}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy && ptr_q == ADDR_W'(i))
          mem_q[i] <= {WIDTH{RST_DATA}};
        else if (wen[i])
          mem_q[i] <= wd;
      end
    end
  end

  // Read muxes; unmatched addresses (>= DEPTH) fall through to 0
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ra1 == ADDR_W'(i)) rd1_d = mem_q[i];
      if (ra2 == ADDR_W'(i)) rd2_d = mem_q[i];
`ifdef BANCO_REG_BYPASS_EN
      if (ra1 == ADDR_W'(i) && wen[i]) rd1_d = wd;
      if (ra2 == ADDR_W'(i) && wen[i]) rd2_d = wd;
`endif
    end
    if (ZERO_REG != 0 && ra1 == '0) rd1_d = '0;
    if (ZERO_REG != 0 && ra2 == '0) rd2_d = '0;
  end

  // Registered read ports; hold data when no read fires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q      <= {WIDTH{RST_DATA}};
      rd2_q      <= {WIDTH{RST_DATA}};
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd1_q <= rd1_d;
        rd2_q <= rd2_d;
      end
    end
  end

  assign rd1      = rd1_q;
  assign rd2      = rd2_q;
  assign rd_valid = rd_valid_q;

endmodule
